mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: a CPU port and a loader/DMA port share one
// single-cycle data memory. Each granted access runs IDLE -> ACCESS -> DONE,
// with round-robin priority between the ports whenever both request at once.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state;
    logic                prio;       // port that wins the next tie
    logic                owner;      // port whose access is in flight
    logic                cmd_we;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;

    logic                grant_valid;
    logic                grant_port;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    // Pick the winning requester and mux its command fields.
    always_comb begin
        grant_valid = req0 | req1;
        grant_port  = (req0 && req1) ? prio : req1;
        sel_we      = grant_port ? we1    : we0;
        sel_addr    = grant_port ? addr1  : addr0;
        sel_wdata   = grant_port ? wdata1 : wdata0;
    end

    // The memory only ever sees the latched command, so requester inputs may
    // change freely once the grant has been taken.
    assign mem_addr  = cmd_addr;
    assign mem_wdata = cmd_wdata;
    assign busy      = (state != IDLE);

    // Arbitration FSM with registered strobes, acks and read-data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prio      <= 1'b0;
            owner     <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner     <= grant_port;
                        cmd_we    <= sel_we;
                        cmd_addr  <= sel_addr;
                        cmd_wdata <= sel_wdata;
                        // Strobes are registered so they are high exactly
                        // for the ACCESS cycle.
                        mem_write <= sel_we;
                        mem_read  <= ~sel_we;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!cmd_we) begin
                        if (owner) begin
                            rdata1 <= mem_rdata;
                        end else begin
                            rdata0 <= mem_rdata;
                        end
                    end
                    ack0  <= ~owner;
                    ack1  <= owner;
                    state <= DONE;
                end
                DONE: begin
                    // Hand the next tie to the port that was just served's peer.
                    prio  <= ~owner;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a behavioural data memory plus directed and
// random requester scenarios checked against a queue-based scoreboard.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
    logic              ack0, ack1, mem_read, mem_write, busy;
    logic [DATA_W-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   port_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] mem     [0:63];
    logic [DATA_W-1:0] ref_mem [0:63];
    logic              mem_clr = 1'b1;
    logic              pre_en  = 1'b0;
    int                pre_idx = 0;
    logic [DATA_W-1:0] pre_val = '0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural memory: combinational read, write on the rising edge.
    always_comb begin
        mem_rdata = '0;
        for (int i = 0; i < 64; i++)
            if (mem_addr == ADDR_W'(i)) mem_rdata = mem[i];
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] = '0;
        end else begin
            if (mem_write)
                for (int i = 0; i < 64; i++)
                    if (mem_addr == ADDR_W'(i)) mem[i] = mem_wdata;
            if (pre_en) mem[pre_idx] = pre_val;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic preload(input int idx, input logic [DATA_W-1:0] val);
        @(negedge clk);
        pre_idx = idx; pre_val = val; pre_en = 1'b1;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_checks++; if ({ack0, ack1, mem_read, mem_write, busy} !== 5'b0) $display("FAIL reset_ctrl: got %b want 00000", {ack0, ack1, mem_read, mem_write, busy}); else n_pass++;
        n_checks++; if (rdata0 !== '0) $display("FAIL reset_rdata0: got %h want 0", rdata0); else n_pass++;
        n_checks++; if (rdata1 !== '0) $display("FAIL reset_rdata1: got %h want 0", rdata1); else n_pass++;
        n_checks++; if (mem_addr !== '0 || mem_wdata !== '0) $display("FAIL reset_cmd: got %h/%h want 0/0", mem_addr, mem_wdata); else n_pass++;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; addr0 = 32'd9; wdata0 = 32'h1234_5678;
        repeat (3) @(negedge clk);
        n_checks++; if ({ack0, ack1, mem_read, mem_write, busy} !== 5'b0) $display("FAIL reset_hold_ctrl: got %b want 00000", {ack0, ack1, mem_read, mem_write, busy}); else n_pass++;
        n_checks++; if (mem_addr !== '0) $display("FAIL reset_hold_addr: got %h want 0", mem_addr); else n_pass++;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        rst = 1'b0; mem_clr = 1'b0;
    endtask

    task automatic test_port0_write();
        exp_t e;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd2; wdata0 = 32'hDEAD_BEEF;
        e.we = 1'b1; e.addr = 32'd2; e.data = 32'hDEAD_BEEF; q0.push_back(e);
        @(negedge clk);
        n_checks++; if ({mem_read, mem_write} !== 2'b01) $display("FAIL p0w_strobes: got %b want 01", {mem_read, mem_write}); else n_pass++;
        n_checks++; if (mem_addr !== 32'd2 || mem_wdata !== 32'hDEAD_BEEF) $display("FAIL p0w_cmd: got %h/%h want 2/deadbeef", mem_addr, mem_wdata); else n_pass++;
        n_checks++; if ({busy, ack0, ack1} !== 3'b100) $display("FAIL p0w_access_ctrl: got %b want 100", {busy, ack0, ack1}); else n_pass++;
        @(negedge clk);
        n_checks++; if ({ack0, ack1, mem_read, mem_write, busy} !== 5'b10001) $display("FAIL p0w_done: got %b want 10001", {ack0, ack1, mem_read, mem_write, busy}); else n_pass++;
        e = q0.pop_front();
        n_checks++; if (mem[e.addr[5:0]] !== e.data) $display("FAIL p0w_memword: got %h want %h", mem[e.addr[5:0]], e.data); else n_pass++;
        req0 = 1'b0; we0 = 1'b0;
        @(negedge clk);
        n_checks++; if ({ack0, busy} !== 2'b00) $display("FAIL p0w_idle: got %b want 00", {ack0, busy}); else n_pass++;
    endtask

    task automatic test_port1_read();
        exp_t e;
        preload(3, 32'h0000_0011);
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd3;
        e.we = 1'b0; e.addr = 32'd3; e.data = 32'h0000_0011; q1.push_back(e);
        @(negedge clk);
        n_checks++; if ({mem_read, mem_write} !== 2'b10) $display("FAIL p1r_strobes: got %b want 10", {mem_read, mem_write}); else n_pass++;
        n_checks++; if (mem_addr !== 32'd3) $display("FAIL p1r_addr: got %h want 3", mem_addr); else n_pass++;
        @(negedge clk);
        e = q1.pop_front();
        n_checks++; if ({ack1, ack0, mem_read} !== 3'b100) $display("FAIL p1r_ack: got %b want 100", {ack1, ack0, mem_read}); else n_pass++;
        n_checks++; if (rdata1 !== e.data) $display("FAIL p1r_rdata: got %h want %h", rdata1, e.data); else n_pass++;
        req1 = 1'b0;
        @(negedge clk);
        n_checks++; if ({ack1, ack0} !== 2'b00) $display("FAIL p1r_ack_pulse: got %b want 00", {ack1, ack0}); else n_pass++;
    endtask

    task automatic test_contention();
        int cyc = 0, last = -1, dbl = 0, p;
        logic [DATA_W-1:0] want;
        preload(10, 32'hA0A0_0010);
        preload(11, 32'hB1B1_0011);
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd11;
        port_q.push_back(0); port_q.push_back(1); port_q.push_back(0); port_q.push_back(1);
        while (port_q.size() != 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (ack0 && ack1) dbl++;
            if (ack0 || ack1) begin
                p = port_q.pop_front();
                want = (p == 1) ? 32'hB1B1_0011 : 32'hA0A0_0010;
                n_checks++; if (int'(ack1) !== p) $display("FAIL cont_order: got port %0d want port %0d", int'(ack1), p); else n_pass++;
                n_checks++; if ((ack1 ? rdata1 : rdata0) !== want) $display("FAIL cont_rdata: got %h want %h", (ack1 ? rdata1 : rdata0), want); else n_pass++;
                if (last >= 0) begin
                    n_checks++; if (cyc - last !== 3) $display("FAIL cont_spacing: got %0d want 3", cyc - last); else n_pass++;
                end
                last = cyc;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        n_checks++; if (port_q.size() !== 0) $display("FAIL cont_timeout: got %0d pending want 0", port_q.size()); else n_pass++;
        port_q.delete();
        n_checks++; if (dbl !== 0) $display("FAIL cont_double_ack: got %0d want 0", dbl); else n_pass++;
    endtask

    task automatic test_input_change();
        preload(5, 32'h5555_5555);
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd2; wdata0 = 32'hCAFE_0002;
        @(negedge clk);
        addr0 = 32'd5; wdata0 = 32'hBAD0_0005;
        #1;
        n_checks++; if (mem_addr !== 32'd2 || mem_wdata !== 32'hCAFE_0002) $display("FAIL chg_cmd: got %h/%h want 2/cafe0002", mem_addr, mem_wdata); else n_pass++;
        @(negedge clk);
        n_checks++; if (ack0 !== 1'b1) $display("FAIL chg_ack: got %b want 1", ack0); else n_pass++;
        req0 = 1'b0; we0 = 1'b0;
        n_checks++; if (mem[2] !== 32'hCAFE_0002) $display("FAIL chg_word2: got %h want cafe0002", mem[2]); else n_pass++;
        n_checks++; if (mem[5] !== 32'h5555_5555) $display("FAIL chg_word5: got %h want 55555555", mem[5]); else n_pass++;
        n_checks++; if (rdata0 !== 32'hA0A0_0010) $display("FAIL chg_rdata0_kept: got %h want a0a00010", rdata0); else n_pass++;
    endtask

    task automatic test_reset_mid_access();
        int stray = 0, cyc = 0;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd6; wdata0 = 32'h0000_0066;
        @(negedge clk);
        n_checks++; if (mem_write !== 1'b1) $display("FAIL rma_pre_write: got %b want 1", mem_write); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if ({mem_write, mem_read, busy, ack0, ack1} !== 5'b0) $display("FAIL rma_abort: got %b want 00000", {mem_write, mem_read, busy, ack0, ack1}); else n_pass++;
        req0 = 1'b0; we0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ack0 || ack1 || busy) stray++;
        end
        n_checks++; if (stray !== 0) $display("FAIL rma_no_ack: got %0d stray cycles want 0", stray); else n_pass++;
        req0 = 1'b1; addr0 = 32'd10; req1 = 1'b1; we1 = 1'b0; addr1 = 32'd11;
        while (!(ack0 || ack1) && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++; if ({ack1, ack0} !== 2'b01) $display("FAIL rma_first_grant: got %b want 01", {ack1, ack0}); else n_pass++;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        exp_t e;
        int viol = 0, bad_words = 0, cyc = 0;
        logic act0 = 1'b0, act1 = 1'b0;
        logic [DATA_W-1:0] last_r0, last_r1;
        last_r0 = rdata0; last_r1 = rdata1;
        for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
        while ((cyc < 1200 || act0 || act1) && cyc < 1400) begin
            @(negedge clk);
            cyc++;
            if (mem_read && mem_write) viol++;
            if ((mem_read || mem_write) && !busy) viol++;
            if (ack0 && ack1) viol++;
            if (ack0) begin
                n_checks++;
                if (q0.size() == 0) $display("FAIL rnd_spurious_ack0: got ack want none");
                else begin
                    e = q0.pop_front();
                    if (!e.we && rdata0 !== e.data) $display("FAIL rnd_rdata0: got %h want %h", rdata0, e.data);
                    else if (e.we && rdata0 !== last_r0) $display("FAIL rnd_rdata0_hold: got %h want %h", rdata0, last_r0);
                    else n_pass++;
                    if (!e.we) last_r0 = e.data;
                end
                act0 = 1'b0; req0 = 1'b0;
            end
            if (ack1) begin
                n_checks++;
                if (q1.size() == 0) $display("FAIL rnd_spurious_ack1: got ack want none");
                else begin
                    e = q1.pop_front();
                    if (!e.we && rdata1 !== e.data) $display("FAIL rnd_rdata1: got %h want %h", rdata1, e.data);
                    else if (e.we && rdata1 !== last_r1) $display("FAIL rnd_rdata1_hold: got %h want %h", rdata1, last_r1);
                    else n_pass++;
                    if (!e.we) last_r1 = e.data;
                end
                act1 = 1'b0; req1 = 1'b0;
            end
            if (cyc < 1200 && !act0 && $urandom_range(0, 2) == 0) begin
                we0 = 1'($urandom_range(0, 1));
                addr0 = ADDR_W'(16 + $urandom_range(0, 15));
                wdata0 = DATA_W'($urandom);
                e.we = we0; e.addr = addr0;
                if (we0) begin ref_mem[addr0[5:0]] = wdata0; e.data = wdata0; end
                else e.data = ref_mem[addr0[5:0]];
                q0.push_back(e);
                req0 = 1'b1; act0 = 1'b1;
            end
            if (cyc < 1200 && !act1 && $urandom_range(0, 2) == 0) begin
                we1 = 1'($urandom_range(0, 1));
                addr1 = ADDR_W'(32 + $urandom_range(0, 15));
                wdata1 = DATA_W'($urandom);
                e.we = we1; e.addr = addr1;
                if (we1) begin ref_mem[addr1[5:0]] = wdata1; e.data = wdata1; end
                else e.data = ref_mem[addr1[5:0]];
                q1.push_back(e);
                req1 = 1'b1; act1 = 1'b1;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        n_checks++; if (q0.size() + q1.size() !== 0) $display("FAIL rnd_missing_acks: got %0d outstanding want 0", q0.size() + q1.size()); else n_pass++;
        n_checks++; if (viol !== 0) $display("FAIL rnd_strobe_rules: got %0d violations want 0", viol); else n_pass++;
        for (int i = 16; i < 48; i++) if (mem[i] !== ref_mem[i]) bad_words++;
        n_checks++; if (bad_words !== 0) $display("FAIL rnd_mem_contents: got %0d bad words want 0", bad_words); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_port0_write();
        test_port1_read();
        test_contention();
        test_input_change();
        test_reset_mid_access();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
